// File: rtl/zap_ibus_fetch_ctrl_pkg.sv
// Shared definitions for the ZAP instruction-side Wishbone fetch controller:
// FSM state encoding, abort payload default and the full-word byte select.
package zap_ibus_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_OUT     = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] ABORT_PAYLOAD_DEFAULT = 32'd0;
    localparam logic [3:0]  WB_SEL_WORD           = 4'hF;

endpackage

// File: rtl/zap_ibus_fetch_ctrl_timeout_ctr.sv
// Bus response watchdog: counts cycles while a transfer is outstanding and
// flags the last permitted cycle. TIMEOUT_CYCLES = 0 disables it entirely.
module zap_bus_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          expired;

            always_comb begin
                expired = i_run && (cnt_q == LAST);
                cnt_d   = cnt_q + 1'b1;
                if (!i_run || i_clr || expired) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign o_expired = expired;
        end
    endgenerate

endmodule

// File: rtl/zap_ibus_fetch_ctrl.sv
// Instruction-side Wishbone classic master: one read per fetch, registered
// instruction/valid/abort toward the fetch stage, with stall and flush.
module zap_ibus_fetch_ctrl
    import zap_ibus_fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ABORT_PAYLOAD  = ABORT_PAYLOAD_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc,
    input  logic        i_fetch_en,
    input  logic        i_stall,
    input  logic        i_clear,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    fetch_state_t state_q, state_d;
    logic         valid_q, valid_d;
    logic         abort_q, abort_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         cyc_q, cyc_d;
    logic         stb_q, stb_d;
    logic [31:0]  adr_q, adr_d;
    logic [3:0]   sel_q, sel_d;

    logic expired;
    logic bus_resp;
    logic fault;
    logic unused_pc_bits;

    assign unused_pc_bits = ^i_pc[1:0];

    zap_bus_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_run     ((state_q == ST_WAIT) || (state_q == ST_DISCARD)),
        .i_clr     (i_wb_ack | i_wb_err),
        .o_expired (expired)
    );

    // An ack on the final watchdog cycle still counts as a good response.
    assign bus_resp = i_wb_ack | i_wb_err | expired;
    assign fault    = i_wb_err | (expired & ~i_wb_ack);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        abort_d = abort_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        sel_d   = sel_q;

        case (state_q)
            ST_IDLE: begin
                if (!i_clear && i_fetch_en && !i_stall) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    sel_d   = WB_SEL_WORD;
                    adr_d   = {i_pc[31:2], 2'b00};
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_resp) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    sel_d = 4'h0;
                end
                // A flush that coincides with the response has nothing left to drain.
                if (i_clear) begin
                    valid_d = 1'b0;
                    abort_d = 1'b0;
                    state_d = bus_resp ? ST_IDLE : ST_DISCARD;
                end else if (bus_resp) begin
                    valid_d = 1'b1;
                    pc_d    = adr_q;
                    state_d = ST_OUT;
                    abort_d = fault;
                    instr_d = fault ? ABORT_PAYLOAD : i_wb_dat;
                end
            end
            ST_OUT: begin
                if (i_clear) begin
                    valid_d = 1'b0;
                    abort_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (!i_stall) begin
                    valid_d = 1'b0;
                    abort_d = 1'b0;
                    state_d = ST_IDLE;
                    if (i_fetch_en) begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        sel_d   = WB_SEL_WORD;
                        adr_d   = {i_pc[31:2], 2'b00};
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DISCARD: begin
                if (bus_resp) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    sel_d   = 4'h0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            adr_q   <= 32'd0;
            sel_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_valid       = valid_q;
    assign o_instr_abort = abort_q;
    assign o_pc          = pc_q;
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = stb_q;
    assign o_wb_adr      = adr_q;
    assign o_wb_sel      = sel_q;

endmodule
